// File: rtl/r200_fwdtrack.sv
// ---------------------------------------------------------------------------
// r200_fwdtrack
//
// Forwarding and load-use hazard tracker for the r200 pipeline. A shift
// register of STAGES entries records the destination of every instruction in
// flight past decode (entry 1 = EX ... entry STAGES = WB). For each of NRD
// decode source operands the youngest matching producer is selected and its
// result (ALU or load data) is driven as the resolved operand; otherwise the
// register-file value passes through. Decode is held while a selected load
// producer has not yet reached LOAD_STAGE.
//
// Optional feature macro: R200_FWDTRACK_STATS_EN
//   defined   -> 32-bit saturating stall-cycle counter on stall_cnt
//   undefined -> no counter register, stall_cnt tied to zero
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   asynchronous active-low reset
//   id_valid    in   ID holds a real instruction
//   id_rd       in   ID destination register
//   id_regwr    in   ID instruction writes rd
//   id_isload   in   ID instruction is a load
//   id_rs       in   NRD x 5-bit source register addresses (port p at [5p +: 5])
//   id_rs_used  in   per-port "operand actually read"
//   rf_data     in   NRD x XLEN register-file read data
//   st_alu      in   STAGES x XLEN ALU result, stage k in slice k-1
//   st_ld       in   STAGES x XLEN load data, stage k in slice k-1
//   flush       in   squash the ID instruction
//   op_out      out  NRD x XLEN resolved operands
//   fwd_sel     out  NRD x CW source select (0 = register file, k = stage k)
//   stall_out   out  hold IF/ID this cycle
//   stall_cnt   out  saturating count of stall cycles
// ---------------------------------------------------------------------------
module r200_fwdtrack #(
   parameter  int STAGES     = 3,
   parameter  int NRD        = 2,
   parameter  int XLEN       = 32,
   parameter  int LOAD_STAGE = 2,
   localparam int CW         = $clog2(STAGES + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   id_valid,
   input  logic [4:0]             id_rd,
   input  logic                   id_regwr,
   input  logic                   id_isload,
   input  logic [NRD*5-1:0]       id_rs,
   input  logic [NRD-1:0]         id_rs_used,
   input  logic [NRD*XLEN-1:0]    rf_data,
   input  logic [STAGES*XLEN-1:0] st_alu,
   input  logic [STAGES*XLEN-1:0] st_ld,
   input  logic                   flush,
   output logic [NRD*XLEN-1:0]    op_out,
   output logic [NRD*CW-1:0]      fwd_sel,
   output logic                   stall_out,
   output logic [31:0]            stall_cnt
);

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       regwr;
      logic       isload;
   } entry_t;

   entry_t ent [1:STAGES];
   logic   hazard;

   // An in-flight entry can supply operand rs only if it really writes a
   // non-zero register and the operand is actually consumed.
   function automatic logic hits(input entry_t e, input logic [4:0] rs, input logic used);
      return e.valid & e.regwr & (e.rd != 5'd0) & (e.rd == rs) & used;
   endfunction

   // -------------------------------------------------------------------------
   // Operand selection and hazard detection
   // -------------------------------------------------------------------------
   always_comb begin
      logic port_hz;
      // NOTE: every output of this block gets a default before any branch,
      // so no path leaves a variable unassigned and no latch is inferred.
      hazard  = 1'b0;
      port_hz = 1'b0;
      fwd_sel = '0;
      op_out  = rf_data;
      for (int p = 0; p < NRD; p++) begin
         port_hz = 1'b0;
         // Scan oldest to youngest; the last hit is the lowest stage, so the
         // youngest producer overrides any older one.
         for (int k = STAGES; k >= 1; k--) begin
            if (hits(ent[k], id_rs[5*p +: 5], id_rs_used[p])) begin
               fwd_sel[CW*p +: CW]  = CW'(k);
               op_out[XLEN*p +: XLEN] = ent[k].isload ? st_ld[XLEN*(k-1) +: XLEN]
                                                      : st_alu[XLEN*(k-1) +: XLEN];
               port_hz = ent[k].isload && (k < LOAD_STAGE);
            end
         end
         hazard = hazard | port_hz;
      end
      hazard = hazard & id_valid;
   end

   // A flushed ID instruction is discarded anyway, so holding it is pointless.
   assign stall_out = hazard & ~flush;

   // -------------------------------------------------------------------------
   // In-flight tracking shift register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: the entries are reset (unlike a data RAM) because their valid
         // bits gate forwarding and stalls straight out of reset.
         for (int k = 1; k <= STAGES; k++) ent[k] <= '0;
      end else begin
         // NOTE: non-blocking assignments make every stage sample the old
         // value of its neighbour, independent of statement order.
         if (stall_out || flush || !id_valid)
            ent[1] <= '0;
         else
            ent[1] <= entry_t'{1'b1, id_rd, id_regwr, id_isload};
         for (int k = 2; k <= STAGES; k++) ent[k] <= ent[k-1];
      end
   end

   // -------------------------------------------------------------------------
   // Stall statistics
   // -------------------------------------------------------------------------
`ifdef R200_FWDTRACK_STATS_EN
   logic [31:0] stall_cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         stall_cnt_q <= '0;
      else if (stall_out && (stall_cnt_q != 32'hFFFF_FFFF))
         stall_cnt_q <= stall_cnt_q + 32'd1;
   end

   assign stall_cnt = stall_cnt_q;
`else
   assign stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_r200_fwdtrack.sv
// ---------------------------------------------------------------------------
// tb_r200_fwdtrack
//
// Directed bench for r200_fwdtrack with default parameters. A behavioural
// model keeps a list of issued instructions stamped with the clock edge at
// which they left ID; an instruction's stage is simply the number of edges
// since then. Every cycle the DUT outputs are compared against that model,
// and selected cycles also carry hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_r200_fwdtrack;

   localparam int STAGES     = 3;
   localparam int NRD        = 2;
   localparam int XLEN       = 32;
   localparam int LOAD_STAGE = 2;
   localparam int CW         = $clog2(STAGES + 1);

`ifdef R200_FWDTRACK_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   localparam logic [31:0] RF0 = 32'h0F0F_0F0F;
   localparam logic [31:0] RF1 = 32'h1111_1111;

   logic                   clk;
   logic                   rst;
   logic                   id_valid;
   logic [4:0]             id_rd;
   logic                   id_regwr;
   logic                   id_isload;
   logic [NRD*5-1:0]       id_rs;
   logic [NRD-1:0]         id_rs_used;
   logic [NRD*XLEN-1:0]    rf_data;
   logic [STAGES*XLEN-1:0] st_alu;
   logic [STAGES*XLEN-1:0] st_ld;
   logic                   flush;
   logic [NRD*XLEN-1:0]    op_out;
   logic [NRD*CW-1:0]      fwd_sel;
   logic                   stall_out;
   logic [31:0]            stall_cnt;

   r200_fwdtrack #(
      .STAGES    (STAGES),
      .NRD       (NRD),
      .XLEN      (XLEN),
      .LOAD_STAGE(LOAD_STAGE)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .id_valid  (id_valid),
      .id_rd     (id_rd),
      .id_regwr  (id_regwr),
      .id_isload (id_isload),
      .id_rs     (id_rs),
      .id_rs_used(id_rs_used),
      .rf_data   (rf_data),
      .st_alu    (st_alu),
      .st_ld     (st_ld),
      .flush     (flush),
      .op_out    (op_out),
      .fwd_sel   (fwd_sel),
      .stall_out (stall_out),
      .stall_cnt (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------------------------------------------------------------
   // Scoreboard counters (written only by the model process)
   // ---------------------------------------------------------------------
   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Literal expectations posted by the stimulus for the current cycle.
   logic        pin_en     = 1'b0;
   int          pin_p      = 0;
   int          pin_sel    = 0;
   logic [31:0] pin_op     = '0;
   logic        pin_stall  = 1'b0;
   logic        pin_cnt_en = 1'b0;
   logic [31:0] pin_cnt    = '0;
   int          preload_seq = 0;

   // ---------------------------------------------------------------------
   // Behavioural model + compare process
   // ---------------------------------------------------------------------
   typedef struct {
      int         issue;
      logic [4:0] rd;
      logic       wr;
      logic       ld;
   } inst_t;

   inst_t       log_q[$];
   int          edges = 0;
   logic [31:0] m_cnt = '0;

   initial begin : model
      int          e_sel [NRD];
      logic        e_ld  [NRD];
      logic [31:0] e_op  [NRD];
      logic        e_haz;
      logic        e_stall;
      int          st;
      int          seen_seq;
      inst_t       ni;
      seen_seq = 0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            log_q.delete();
            m_cnt = '0;
         end
         if (preload_seq != seen_seq) begin
            seen_seq = preload_seq;
            m_cnt    = 32'hFFFF_FFFE;
         end
         e_haz = 1'b0;
         for (int p = 0; p < NRD; p++) begin
            e_sel[p] = 0;
            e_ld[p]  = 1'b0;
            foreach (log_q[i]) begin
               st = edges - log_q[i].issue + 1;
               if (st >= 1 && st <= STAGES && log_q[i].wr && log_q[i].rd != 5'd0 &&
                   log_q[i].rd == id_rs[5*p +: 5] && id_rs_used[p] &&
                   (e_sel[p] == 0 || st < e_sel[p])) begin
                  e_sel[p] = st;
                  e_ld[p]  = log_q[i].ld;
               end
            end
            if (e_sel[p] == 0)  e_op[p] = rf_data[XLEN*p +: XLEN];
            else if (e_ld[p])   e_op[p] = st_ld[XLEN*(e_sel[p]-1) +: XLEN];
            else                e_op[p] = st_alu[XLEN*(e_sel[p]-1) +: XLEN];
            if (id_valid && e_sel[p] != 0 && e_ld[p] && e_sel[p] < LOAD_STAGE) e_haz = 1'b1;
         end
         e_stall = e_haz && !flush;

         for (int p = 0; p < NRD; p++) begin
            check($sformatf("fwd_sel[%0d]", p), 32'(fwd_sel[CW*p +: CW]), 32'(e_sel[p]));
            check($sformatf("op_out[%0d]", p), op_out[XLEN*p +: XLEN], e_op[p]);
         end
         check("stall_out", 32'(stall_out), 32'(e_stall));
         check("stall_cnt", stall_cnt, m_cnt);

         if (pin_en) begin
            check("lit_sel",   32'(fwd_sel[CW*pin_p +: CW]), 32'(pin_sel));
            check("lit_op",    op_out[XLEN*pin_p +: XLEN], pin_op);
            check("lit_stall", 32'(stall_out), 32'(pin_stall));
         end
         if (pin_cnt_en) check("lit_cnt", stall_cnt, pin_cnt);

         @(posedge clk);
         edges++;
         if (rst) begin
            if (STATS && e_stall && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
            if (id_valid && !flush && !e_stall) begin
               ni = '{issue: edges, rd: id_rd, wr: id_regwr, ld: id_isload};
               log_q.push_back(ni);
            end
            while (log_q.size() > 0 && (edges - log_q[0].issue + 1) > STAGES)
               void'(log_q.pop_front());
         end
      end
   end

   // ---------------------------------------------------------------------
   // Stimulus helpers
   // ---------------------------------------------------------------------
   task automatic step(input logic v, input logic [4:0] rd, input logic wr, input logic ld,
                       input logic [4:0] r0, input logic [4:0] r1, input logic [1:0] used,
                       input logic fl);
      @(posedge clk);
      #1;
      id_valid   = v;
      id_rd      = rd;
      id_regwr   = wr;
      id_isload  = ld;
      id_rs      = {r1, r0};
      id_rs_used = used;
      flush      = fl;
      pin_en     = 1'b0;
      pin_cnt_en = 1'b0;
   endtask

   task automatic pin(input int p, input int sel, input logic [31:0] op, input logic stl);
      pin_en    = 1'b1;
      pin_p     = p;
      pin_sel   = sel;
      pin_op    = op;
      pin_stall = stl;
   endtask

   task automatic pin_c(input logic [31:0] c);
      pin_cnt_en = 1'b1;
      pin_cnt    = c;
   endtask

   // ---------------------------------------------------------------------
   // Directed sequence
   // ---------------------------------------------------------------------
   initial begin
      rst        = 1'b0;
      id_valid   = 1'b0;
      id_rd      = '0;
      id_regwr   = 1'b0;
      id_isload  = 1'b0;
      id_rs      = '0;
      id_rs_used = '0;
      flush      = 1'b0;
      rf_data    = {RF1, RF0};
      st_alu     = {32'hA3A3_A3A3, 32'hA2A2_A2A2, 32'h0000_1234};
      st_ld      = {32'hC3C3_C3C3, 32'hDEAD_BEEF, 32'hC1C1_C1C1};

      // Reset held with a live ID instruction reading x5.
      step(1, 5, 1, 0, 5, 0, 2'b11, 0); pin(0, 0, RF0, 0); pin_c(32'd0);
      step(1, 5, 1, 0, 5, 0, 2'b11, 0); pin(0, 0, RF0, 0); pin_c(32'd0);
      // Release with ID idle: entries stay empty.
      step(0, 0, 0, 0, 5, 0, 2'b01, 0); rst = 1'b1; pin(0, 0, RF0, 0);
      step(0, 0, 0, 0, 5, 0, 2'b01, 0); pin(0, 0, RF0, 0);

      // ALU forward: add x5, then consumers one and two cycles later.
      step(1, 5, 1, 0, 0, 0, 2'b00, 0);
      step(1, 8, 1, 0, 5, 0, 2'b01, 0); pin(0, 1, 32'h0000_1234, 0);
      step(1, 9, 1, 0, 5, 0, 2'b01, 0); pin(0, 2, 32'hA2A2_A2A2, 0);

      // Load-use: lw x6, consumer on port 1 stalls exactly one cycle.
      step(1, 6, 1, 1, 0, 0, 2'b00, 0);
      step(1, 10, 1, 0, 0, 6, 2'b10, 0); pin(1, 1, 32'hC1C1_C1C1, 1);
      step(1, 10, 1, 0, 0, 6, 2'b10, 0); pin(1, 2, 32'hDEAD_BEEF, 0);
      pin_c(STATS ? 32'd1 : 32'd0);
      step(0, 0, 0, 0, 0, 0, 2'b00, 0);

      // Youngest producer wins.
      step(1, 7, 1, 0, 0, 0, 2'b00, 0);
      step(1, 7, 1, 0, 0, 0, 2'b00, 0);
      step(1, 11, 1, 0, 7, 7, 2'b11, 0); pin(0, 1, 32'h0000_1234, 0);

      // x0 is never forwarded, even from a load.
      step(1, 0, 1, 1, 0, 0, 2'b00, 0);
      step(1, 11, 1, 0, 0, 0, 2'b01, 0); pin(0, 0, RF0, 0);

      // Unused operand does not forward or stall.
      step(1, 6, 1, 1, 0, 0, 2'b00, 0);
      step(1, 11, 1, 0, 6, 6, 2'b00, 0); pin(0, 0, RF0, 0);

      // Flush during a load-use hazard: no stall, bubble, counter unchanged.
      step(1, 12, 1, 1, 0, 0, 2'b00, 0);
      step(1, 13, 1, 0, 12, 0, 2'b01, 1); pin(0, 1, 32'hC1C1_C1C1, 0);
      pin_c(STATS ? 32'd1 : 32'd0);
      step(1, 14, 1, 0, 12, 13, 2'b11, 0); pin(0, 2, 32'hDEAD_BEEF, 0);
      pin_c(STATS ? 32'd1 : 32'd0);

      // Hazard qualified by id_valid.
      step(1, 14, 1, 1, 0, 0, 2'b00, 0);
      step(0, 0, 0, 0, 14, 0, 2'b01, 0); pin(0, 1, 32'hC1C1_C1C1, 0);

      // Reset asserted while stalling clears the stall at once.
      step(1, 20, 1, 1, 0, 0, 2'b00, 0);
      step(1, 15, 1, 0, 20, 0, 2'b01, 0); pin(0, 1, 32'hC1C1_C1C1, 1);
      step(1, 15, 1, 0, 20, 0, 2'b01, 0); rst = 1'b0; pin(0, 0, RF0, 0); pin_c(32'd0);
      step(0, 0, 0, 0, 0, 0, 2'b00, 0); rst = 1'b1;

      // Saturation: preload near the top, then three load-use stalls.
      step(0, 0, 0, 0, 0, 0, 2'b00, 0);
`ifdef R200_FWDTRACK_STATS_EN
      dut.stall_cnt_q = 32'hFFFF_FFFE;
      preload_seq++;
`endif
      for (int i = 0; i < 3; i++) begin
         step(1, 21, 1, 1, 0, 0, 2'b00, 0);
         step(1, 16, 1, 0, 21, 0, 2'b01, 0); pin(0, 1, 32'hC1C1_C1C1, 1);
         step(1, 16, 1, 0, 21, 0, 2'b01, 0); pin(0, 2, 32'hDEAD_BEEF, 0);
         pin_c(STATS ? 32'hFFFF_FFFF : 32'd0);
      end

      step(0, 0, 0, 0, 0, 0, 2'b00, 0);
      @(posedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
